// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register: captures decoder controls and datapath
// values, supports stall/flush, masks controls of unimplemented opcodes.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALUCTRL_WIDTH  = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      ValidD,
    input  logic [6:0]                OpD,
    input  logic                      RegWriteD,
    input  logic                      MemWriteD,
    input  logic                      JumpD,
    input  logic                      BranchD,
    input  logic                      ALUSrcD,
    input  logic [1:0]                ResultSrcD,
    input  logic [ALUCTRL_WIDTH-1:0]  ALUControlD,
    input  logic [2:0]                Funct3D,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      RegWriteE,
    output logic                      MemWriteE,
    output logic                      JumpE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic [1:0]                ResultSrcE,
    output logic [ALUCTRL_WIDTH-1:0]  ALUControlE,
    output logic [2:0]                Funct3E,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      ValidE,
    output logic                      IllegalE,
    output logic [CNT_WIDTH-1:0]      BubbleCount
);

    localparam int NUM_OPS = 8;
    localparam logic [NUM_OPS*7-1:0] SUPPORTED_OPS = {
        7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
        7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111
    };

    logic [NUM_OPS-1:0] op_match;
    logic               op_legal;
    logic               load_bubble;
    logic               load_instr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
            assign op_match[gi] = (OpD == SUPPORTED_OPS[gi*7 +: 7]);
        end
    endgenerate

    assign op_legal    = |op_match;
    assign load_bubble = FlushE | (~StallE & ~ValidD);
    assign load_instr  = ~FlushE & ~StallE & ValidD;

    // Control fields of an illegal opcode are masked with op_legal so that
    // undriven decoder outputs can never reach execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || load_bubble) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= '0;
            Funct3E     <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            ValidE      <= 1'b0;
            IllegalE    <= 1'b0;
        end else if (load_instr) begin
            RegWriteE   <= op_legal ? RegWriteD   : 1'b0;
            MemWriteE   <= op_legal ? MemWriteD   : 1'b0;
            JumpE       <= op_legal ? JumpD       : 1'b0;
            BranchE     <= op_legal ? BranchD     : 1'b0;
            ALUSrcE     <= op_legal ? ALUSrcD     : 1'b0;
            ResultSrcE  <= op_legal ? ResultSrcD  : 2'b00;
            ALUControlE <= op_legal ? ALUControlD : '0;
            Funct3E     <= Funct3D;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            PCE         <= PCD;
            ImmExtE     <= ImmExtD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
            ValidE      <= 1'b1;
            IllegalE    <= ~op_legal;
        end
    end

    // Saturating count of inserted bubbles; illegal instructions do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BubbleCount <= '0;
        end else if (load_bubble && (BubbleCount != {CNT_WIDTH{1'b1}})) begin
            BubbleCount <= BubbleCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Bench for id_ex_pipeline_reg: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic        rw, mw, j, b, asrc;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic [2:0]  f3;
        logic [31:0] rd1, rd2, pc, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
    } bundle_t;

    typedef struct packed {
        bundle_t     b;
        logic        valid, illegal;
        logic [3:0]  cnt;
    } out_t;

    typedef struct {
        logic        stall, flush, valid;
        logic [6:0]  op;
        logic        rw, mw, j, b, asrc;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        xrw, xmw, xj, xb, xasrc;
        logic [1:0]  xrsrc;
        logic [4:0]  xrd;
        logic [31:0] ximm;
        logic        xvalid, xill;
        logic [3:0]  xcnt;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       stall, flush, validd;
    logic [6:0] opd;
    bundle_t    din;
    out_t       act;

    logic        e_rw, e_mw, e_j, e_b, e_asrc;
    logic [1:0]  e_rsrc;
    logic [2:0]  e_aluc, e_f3;
    logic [31:0] e_rd1, e_rd2, e_pc, e_imm, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_valid, e_ill;
    logic [3:0]  e_cnt;

    int compared   = 0;
    int mismatched = 0;

    id_ex_pipeline_reg #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALUCTRL_WIDTH(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush),
        .ValidD(validd), .OpD(opd),
        .RegWriteD(din.rw), .MemWriteD(din.mw), .JumpD(din.j), .BranchD(din.b),
        .ALUSrcD(din.asrc), .ResultSrcD(din.rsrc), .ALUControlD(din.aluc),
        .Funct3D(din.f3), .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc),
        .ImmExtD(din.imm), .PCPlus4D(din.pc4),
        .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .RegWriteE(e_rw), .MemWriteE(e_mw), .JumpE(e_j), .BranchE(e_b),
        .ALUSrcE(e_asrc), .ResultSrcE(e_rsrc), .ALUControlE(e_aluc),
        .Funct3E(e_f3), .RD1E(e_rd1), .RD2E(e_rd2), .PCE(e_pc),
        .ImmExtE(e_imm), .PCPlus4E(e_pc4),
        .Rs1E(e_rs1), .Rs2E(e_rs2), .RdE(e_rd),
        .ValidE(e_valid), .IllegalE(e_ill), .BubbleCount(e_cnt)
    );

    assign act = {e_rw, e_mw, e_j, e_b, e_asrc, e_rsrc, e_aluc, e_f3,
                  e_rd1, e_rd2, e_pc, e_imm, e_pc4, e_rs1, e_rs2, e_rd,
                  e_valid, e_ill, e_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    // Behavioural model: one edge of the execute-stage slot.
    function automatic out_t model_step(out_t cur, logic s, logic f, logic v,
                                        logic [6:0] op, bundle_t d);
        out_t n = cur;
        if (f || (!s && !v)) begin
            n     = '0;
            n.cnt = (cur.cnt == 4'd15) ? 4'd15 : cur.cnt + 4'd1;
        end else if (!s) begin
            n.b       = d;
            n.valid   = 1'b1;
            n.illegal = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                                     7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111});
            if (n.illegal) begin
                {n.b.rw, n.b.mw, n.b.j, n.b.b, n.b.asrc} = 5'b0;
                n.b.rsrc = 2'b00;
                n.b.aluc = 3'b000;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input out_t exp, input out_t mask);
        compared++;
        if (((act ^ exp) & mask) !== '0) begin
            mismatched++;
            $display("FAIL %s: got %h required %h (mask %h)", name, act & mask, exp & mask, mask);
        end else begin
            $display("ok   %s: %h", name, act & mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed();
        din.aluc = 3'd5;  din.f3 = 3'd2;
        din.rd1 = 32'hA1A1_0001; din.rd2 = 32'hB2B2_0002;
        din.pc = 32'h0000_0100;  din.pc4 = 32'h0000_0104;
        din.rs1 = 5'd1; din.rs2 = 5'd2;
    endtask

    vec_t tbl[15];
    out_t full, m_tbl, m_ctl, m_cnt, exp_o, model;
    logic [6:0] legal_ops[8];

    initial begin
        full  = '1;
        m_tbl = '0;
        {m_tbl.b.rw, m_tbl.b.mw, m_tbl.b.j, m_tbl.b.b, m_tbl.b.asrc} = 5'h1F;
        m_tbl.b.rsrc = '1; m_tbl.b.rd = '1; m_tbl.b.imm = '1;
        m_tbl.valid = 1'b1; m_tbl.illegal = 1'b1; m_tbl.cnt = '1;
        m_ctl = '0;
        {m_ctl.b.rw, m_ctl.b.mw, m_ctl.b.j, m_ctl.b.b, m_ctl.b.asrc} = 5'h1F;
        m_ctl.b.rsrc = '1; m_ctl.b.aluc = '1;
        m_ctl.valid = 1'b1; m_ctl.illegal = 1'b1; m_ctl.cnt = '1;
        m_cnt = '0;
        m_cnt.valid = 1'b1; m_cnt.cnt = '1;

        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                      7'b0010011, 7'b0110111, 7'b1101111, 7'b1100111};

        //          s     f     v     op          rw    mw    j     b     as    rs     rd     imm            xrw   xmw   xj    xb    xas   xrs    xrd    ximm           xv    xi    xc
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 7'b0000011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd5, 32'h10,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd5, 32'h10,        1'b1, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 7'b0100011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 32'h8,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 32'h8,         1'b1, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 32'h8,         1'b1, 1'b0, 4'd0};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0,         1'b0, 1'b0, 4'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'b0001111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'h44,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd9, 32'h44,        1'b1, 1'b1, 4'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 7'b1101111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd1, 32'h100,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd1, 32'h100,       1'b1, 1'b0, 4'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd3, 32'hC,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd3, 32'hC,         1'b1, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd7, 32'h20,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0,         1'b0, 1'b0, 4'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd6, 32'h30,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd6, 32'h30,        1'b1, 1'b1, 4'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 7'b0110111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 32'h12345000,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 32'h12345000,  1'b1, 1'b0, 4'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd2, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0,         1'b0, 1'b0, 4'd3};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd2, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0,         1'b0, 1'b0, 4'd3};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 7'b1100111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 5'd8, 32'h4,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 5'd8, 32'h4,         1'b1, 1'b0, 4'd3};

        // Reset state
        stall = 1'b0; flush = 1'b0; validd = 1'b0; opd = 7'd0; din = '0;
        set_fixed();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(); step();
        check("reset_state", '0, full);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush; validd = tbl[i].valid; opd = tbl[i].op;
            {din.rw, din.mw, din.j, din.b, din.asrc} =
                {tbl[i].rw, tbl[i].mw, tbl[i].j, tbl[i].b, tbl[i].asrc};
            din.rsrc = tbl[i].rsrc; din.rd = tbl[i].rd; din.imm = tbl[i].imm;
            step();
            exp_o = '0;
            {exp_o.b.rw, exp_o.b.mw, exp_o.b.j, exp_o.b.b, exp_o.b.asrc} =
                {tbl[i].xrw, tbl[i].xmw, tbl[i].xj, tbl[i].xb, tbl[i].xasrc};
            exp_o.b.rsrc = tbl[i].xrsrc; exp_o.b.rd = tbl[i].xrd; exp_o.b.imm = tbl[i].ximm;
            exp_o.valid = tbl[i].xvalid; exp_o.illegal = tbl[i].xill; exp_o.cnt = tbl[i].xcnt;
            check($sformatf("vec%0d", i), exp_o, m_tbl);
        end

        // Asynchronous reset mid-cycle, no clock edge needed
        stall = 1'b1; flush = 1'b0;
        #3 rst_n = 1'b0;
        #1 check("async_reset_midcycle", '0, full);
        step();
        #2 rst_n = 1'b1;
        stall = 1'b0;

        // Illegal opcode with undriven controls
        validd = 1'b1; opd = 7'b0001111;
        {din.rw, din.mw, din.j, din.b, din.asrc} = 5'bxxxxx;
        din.rsrc = 2'bxx; din.aluc = 3'bxxx;
        step();
        exp_o = '0; exp_o.valid = 1'b1; exp_o.illegal = 1'b1;
        check("illegal_x_controls", exp_o, m_ctl);
        set_fixed();

        // Counter saturation over 20 bubbles
        validd = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_o = '0;
            exp_o.cnt = (i > 15) ? 4'd15 : 4'(i);
            check($sformatf("sat_edge%0d", i), exp_o, m_cnt);
        end

        // Randomized traffic against the model, with periodic resets
        rst_n = 1'b0; #2 rst_n = 1'b1;
        model = '0;
        for (int i = 0; i < 320; i++) begin
            logic [191:0] rb;
            logic [31:0]  r;
            if (i % 64 == 63) begin
                #3 rst_n = 1'b0;
                #1 check($sformatf("rnd_reset%0d", i), '0, full);
                model = '0;
                #1 rst_n = 1'b1;
            end
            rb = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            din    = rb[187:0];
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            validd = ($urandom_range(0, 4) != 0);
            r = $urandom();
            if ($urandom_range(0, 4) != 0) opd = legal_ops[r[2:0]];
            else                           opd = r[14:8];
            model = model_step(model, stall, flush, validd, opd, din);
            step();
            check($sformatf("rnd%0d", i), model, full);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
